// File: rtl/pipelined_carry_adder_pkg.sv
// pipelined_carry_adder_pkg: mode encodings, slice sizing and configuration legality for the pipelined adder
`define PCA_CHECK_CFG(w, s) \
  if (!pipelined_carry_adder_pkg::cfg_ok(w, s)) begin : g_bad_cfg \
    $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH"); \
  end

package pipelined_carry_adder_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
  function automatic bit cfg_ok(int width, int stages);
    return stages >= 1 && stages <= width && width % stages == 0;
  endfunction
  function automatic int slice_width(int width, int stages);
    return stages >= 1 ? width / stages : width;
  endfunction
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: combinational WIDTH-bit ripple adder used as one pipeline slice
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic c;
  // carry ripples from bit 0 upward, one full adder per bit
  always_comb begin
    c = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: STAGES-deep sliced add/subtract with registered inter-slice carry and valid/ready flow control
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SLICE = slice_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  `PCA_CHECK_CFG(WIDTH, STAGES)

  logic             adv;
  logic [WIDTH-1:0] eb;
  logic             ec;
  logic             unused_bits;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign eb       = sub == ADD ? b : ~b;
  assign ec       = sub == SUB ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : st
    logic             pv, pc, v, rc, c;
    logic [WIDTH-1:0] pa, pb, ps, ns, ra, rb, rs;
    logic [SLICE-1:0] s;
    if (k == 0) begin : g_src
      assign pv = in_valid;
      assign pa = a;
      assign pb = eb;
      assign ps = '0;
      assign pc = ec;
    end else begin : g_src
      assign pv = st[k-1].v;
      assign pa = st[k-1].ra;
      assign pb = st[k-1].rb;
      assign ps = st[k-1].rs;
      assign pc = st[k-1].rc;
    end
    ripple_carry_adder #(.WIDTH(SLICE)) u_rca (
      .a   (pa[k*SLICE +: SLICE]),
      .b   (pb[k*SLICE +: SLICE]),
      .cin (pc),
      .sum (s),
      .cout(c)
    );
    // splice this stage's slice into the partial result carried up from lower stages
    always_comb begin
      ns = ps;
      ns[k*SLICE +: SLICE] = s;
    end
    // stage register: every stage advances together; data only loads behind a valid op so outputs never go X
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v  <= 1'b0;
        ra <= '0;
        rb <= '0;
        rs <= '0;
        rc <= 1'b0;
      end else if (adv) begin
        v <= pv;
        if (pv) begin
          ra <= pa;
          rb <= pb;
          rs <= ns;
          rc <= c;
        end
      end
  end

  // signed overflow registered alongside the final slice, from the operand sign bits carried down the pipe
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (adv && st[LAST].pv)
      ovf <= (st[LAST].pa[WIDTH-1] == st[LAST].pb[WIDTH-1]) && (st[LAST].s[SLICE-1] != st[LAST].pa[WIDTH-1]);

  assign out_valid   = st[LAST].v;
  assign sum         = st[LAST].rs;
  assign cout        = st[LAST].rc;
  assign unused_bits = ^{st[LAST].ra, st[LAST].rb};
endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
Parametrised, pipelined successor to the combinational ripple carry adder: add/subtract of two WIDTH-bit operands, split into STAGES ripple slices with a registered carry between slices. Valid/ready handshakes on both sides, full throughput of one operation per cycle, and signed-overflow reporting. Sits in the arithmetic datapath wherever a wide adder must close timing at the system clock.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (slices); 1..WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept; transfer when in_valid && in_ready at a rising edge.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0: a+b+cin; 1: a-b-cin.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of MSB (sub: 1 = no borrow).
ovf  output  1  two's-complement signed overflow.

Behaviour:
- One clock (clk); reset is asynchronous, active-high (rst). On rst: all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 immediately after rst deasserts.
- SLICE = WIDTH/STAGES. Non-multiple, or STAGES outside 1..WIDTH, is an elaboration error.
- Sub mode: effective B = ~b, effective carry-in = ~cin; arithmetic otherwise identical.
- Stage k (0-based) adds slice k of the (skewed) A/B using the carry registered by stage k-1 (stage 0 uses the effective carry-in). Lower result slices and upper operand slices travel in delay registers so all parts of one operation exit together.
- Latency: an operation accepted at edge 1 appears on sum/cout/ovf with out_valid=1 just after edge STAGES. STAGES=1 is a plain registered adder.
- ovf = (A[MSB] == effB[MSB]) && (sum[MSB] != A[MSB]), computed in the last stage; requires A[MSB] and effB[MSB] carried down the pipe.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready; documented path). When adv=0 every stage holds, including data and valid bits. When adv=1 every stage shifts; stage 0 loads in_valid (bubble when in_valid=0).
- Bubbles are not compressed; throughput is one op/cycle when out_ready stays high.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous accept and output pop in the same cycle is legal and required for full throughput.
- rst mid-operation flushes all in-flight operations; no partial results are emitted.
- sum/cout/ovf are don't-care when out_valid=0, but they hold their last value and never go X after reset.

Decomposition:
- Shared include/package: localparam SLICE width derivation, the parameter-legality check macro, and mode encoding constants ADD=1'b0, SUB=1'b1.
- Sub-module: existing ripple_carry_adder instantiated STAGES times with WIDTH=SLICE as the per-stage combinational slice. All registers, skew logic and handshakes live in pipelined_carry_adder.

Test Plan:
- WIDTH=8, STAGES=2: a=0F, b=01, cin=0, sub=0 -> after 2 edges sum=10, cout=0, ovf=0.
- FF+01, cin=0 -> sum=00, cout=1, ovf=0; then 7F+7F, cin=1 -> sum=FF, cout=0, ovf=1.
- sub=1: 00-01, cin=0 -> sum=FF, cout=0 (borrow), ovf=0; 80-01 -> sum=7F, cout=1, ovf=1.
- Back-to-back: 5 ops on consecutive cycles with out_ready=1 -> 5 results on consecutive cycles, in order, correct values; in_ready constantly 1.
- Backpressure: out_ready=0 for 4 cycles with pipe full -> in_ready=0, sum/cout/ovf frozen, no loss or duplication; on release, results drain in order.
- Reset: assert rst with 2 ops in flight -> out_valid=0 and all outputs 0 asynchronously, nothing emitted afterwards; repeat the whole set with WIDTH=32, STAGES=4 and STAGES=1 against a behavioural a±b model (1000 random ops).
